// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: start/busy/done handshake bundle for the shift sequencer.
// master drives start/op/data_in/shamt; slave returns busy/done/data_out.
interface shift_sequencer_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [1:0]         op;
  logic [DATA_W-1:0]  data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [DATA_W-1:0]  data_out;

  modport master (
    output start,
    output op,
    output data_in,
    output shamt,
    input  busy,
    input  done,
    input  data_out
  );

  modport slave (
    input  start,
    input  op,
    input  data_in,
    input  shamt,
    output busy,
    output done,
    output data_out
  );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: one-bit-per-clock SLL/SRL/SRA/ROR unit replacing a barrel shifter.
// Ports: clk, reset_n (async, active-low), bus (slave: start/op/data_in/shamt in; busy/done/data_out out).
module shift_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input logic              clk,
  input logic              reset_n,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;

  function automatic logic [DATA_W-1:0] shift1(
    input logic [1:0]        op,
    input logic [DATA_W-1:0] d
  );
    logic [DATA_W-1:0] r;
    r = d;
    unique case (op)
      OP_SLL: r = {d[DATA_W-2:0], 1'b0};
      OP_SRL: r = {1'b0, d[DATA_W-1:1]};
      OP_SRA: r = {d[DATA_W-1], d[DATA_W-1:1]};
      OP_ROR: r = {d[0], d[DATA_W-1:1]};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // DONE accepts a new start just like IDLE, giving back-to-back ops.
  // Exit on cnt==1 so the counter never wraps below zero.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          data_d  = bus.data_in;
          op_d    = bus.op;
          cnt_d   = bus.shamt;
          state_d = (bus.shamt == '0) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        data_d = shift1(op_q, data_q);
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state_q == SHIFT);
    bus.done     = (state_q == DONE);
    bus.data_out = data_q;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle barrel-shift replacement; sits directly downstream of the 3:1 shifter-input mux and consumes its 32-bit output as the shift operand.
- Loads the operand, then shifts one bit position per clock for shamt cycles under a start/busy/done handshake.
- Holds the result on data_out for the register-file write-back mux.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on a rising edge only when the block is not busy.
- op  in  2  shift type, latched at start: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- data_in  in  DATA_W  operand from the shifter-input mux, latched at start.
- shamt  in  SHAMT_W  shift amount 0..31, latched at start.
- busy  out  1  high while shifting.
- done  out  1  one-cycle pulse when the result is valid.
- data_out  out  DATA_W  working/result register.

Behaviour:
- Reset: asynchronous and active-low, one clock. Asserting reset_n=0 at any time, including mid-shift, immediately forces:
  - state to IDLE, data_out to 0, counter to 0, latched op to 00;
  - busy and done to 0.
- Release of reset is synchronous to the next edge.
- FSM states are IDLE, SHIFT and DONE.
  - busy = (state==SHIFT).
  - done = (state==DONE).
  - Both are registered-state decodes with no combinational path from the inputs.
- IDLE or DONE with start=1, at edge E0:
  - data_out <= data_in; op latched; cnt <= shamt.
  - Next state is DONE if shamt==0, otherwise SHIFT.
- SHIFT, each edge:
  - data_out is shifted by one bit and cnt <= cnt-1.
  - When cnt==1 before the edge, the next state is DONE; otherwise the state stays SHIFT.
- One-bit shift rules:
  - SLL: {d[30:0],0}.
  - SRL: {0,d[31:1]}.
  - SRA: {d[31],d[31:1]}.
  - ROR: {d[0],d[31:1]}.
- Latency: done is high in the cycle after edge E_N, where N = shamt.
  - For shamt=0 this is the cycle after E0.
  - Total cycles from start to done = N+1.
- DONE without start: the next state is IDLE. done is exactly one cycle wide.
- DONE with start: the new operation is accepted (back-to-back). done falls, and the new load occurs on the same edge.
- start while SHIFT: ignored. No re-latch of data_in, op or shamt. The result is unaffected.
- data_in, op and shamt may change freely after E0 without effect.
- data_out holds the last result in IDLE until the next accepted start or reset.
- In SHIFT, data_out shows intermediate values; the consumer samples only on done.
- Widths: cnt is SHAMT_W bits and never underflows (exit at cnt==1).

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with start=1 -> data_out=0, busy=0, done=0. Release reset_n, keep start=0 -> state stays IDLE.
- SLL: data_in=0x0000_0001, shamt=4, op=00, start for 1 cycle -> busy high for 4 cycles. done pulse in cycle 5 with data_out=0x0000_0010. Then IDLE, and data_out is held.
- SRA/SRL: data_in=0x8000_00F0, shamt=8:
  - op=10 -> result 0xFF80_0000;
  - op=01 -> result 0x0080_0000.
- ROR and boundaries:
  - data_in=0x0000_0001, shamt=31, op=11 -> done after 32 cycles, data_out=0x0000_0002.
  - shamt=0 with any op -> done in the cycle after start, data_out=data_in.
- Handshake:
  - start held high during SHIFT with data_in changed to 0xDEAD_BEEF -> the first result is unchanged.
  - start high during the done cycle -> a second op begins with no IDLE gap, and each done is exactly 1 cycle.
- Reset mid-shift: pull reset_n low asynchronously between edges at cnt=3 -> busy, done and data_out go to 0 immediately. After release, a fresh op completes correctly.
